// File: rtl/cond_eval_if.sv
// ============================================================================
// Module      : cond_eval_if
// Description : Flag-write, save/restore and condition-query bundle between
//               the ALU/control side (master) and cond_eval (slave).
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface cond_eval_if;
    logic       flag_we;
    logic [3:0] flags_in;
    logic       sign_in;
    logic       save;
    logic       restore;
    logic       cond_req;
    logic [3:0] cond;
    logic       cond_ready;
    logic       cond_valid;
    logic       cond_true;
    logic [3:0] flags_out;

    modport master (
        output flag_we, flags_in, sign_in, save, restore, cond_req, cond,
        input  cond_ready, cond_valid, cond_true, flags_out
    );

    modport slave (
        input  flag_we, flags_in, sign_in, save, restore, cond_req, cond,
        output cond_ready, cond_valid, cond_true, flags_out
    );
endinterface

`default_nettype wire

// File: rtl/cond_eval.sv
// ============================================================================
// Module      : cond_eval
// Description : Status-flag register with shadow copy and ARM-style condition
//               evaluator. Define FLAG_FWD_EN to evaluate queries against the
//               forwarded next-status value (no WAIT stall).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cond_eval (
    input  wire logic   clk,
    input  wire logic   reset,
    cond_eval_if.slave  bus
);

    // Flag word bit positions: bit0=V, bit1=N, bit2=Z, bit3=C
    localparam logic [3:0] C_UNSIGNED_MASK = 4'b1100;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_status;
    logic [3:0] r_shadow;
    logic [3:0] r_cond_lat;
    logic       r_valid;
    logic       r_true;

    logic [3:0] w_flags_masked;
    logic [3:0] w_status_nxt;
    logic       w_status_wr;
    logic       w_valid_nxt;
    logic       w_true_nxt;
    logic       w_lat_we;

    function automatic logic f_eval(input logic [3:0] sel, input logic [3:0] fl);
        logic v;
        logic n;
        logic z;
        logic c;
        v = fl[0];
        n = fl[1];
        z = fl[2];
        c = fl[3];
        f_eval = 1'b0;
        case (sel)
            4'h0: f_eval = z;
            4'h1: f_eval = !z;
            4'h2: f_eval = c;
            4'h3: f_eval = !c;
            4'h4: f_eval = n;
            4'h5: f_eval = !n;
            4'h6: f_eval = v;
            4'h7: f_eval = !v;
            4'h8: f_eval = c & !z;
            4'h9: f_eval = !c | z;
            4'hA: f_eval = (n == v);
            4'hB: f_eval = (n != v);
            4'hC: f_eval = !z & (n == v);
            4'hD: f_eval = z | (n != v);
            4'hE: f_eval = 1'b1;
            default: f_eval = 1'b0;
        endcase
    endfunction

    // Unsigned ops never report overflow or negative
    always_comb begin
        w_flags_masked = bus.sign_in ? bus.flags_in : (bus.flags_in & C_UNSIGNED_MASK);
        w_status_wr    = bus.restore | bus.flag_we;
        if (bus.restore) begin
            w_status_nxt = r_shadow;
        end else if (bus.flag_we) begin
            w_status_nxt = w_flags_masked;
        end else begin
            w_status_nxt = r_status;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = 1'b0;
        w_true_nxt  = r_true;
        w_lat_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cond_req) begin
`ifdef FLAG_FWD_EN
                    w_valid_nxt = 1'b1;
                    w_true_nxt  = f_eval(bus.cond, w_status_nxt);
`else
                    // A coincident status write defers evaluation by one cycle
                    if (w_status_wr) begin
                        w_lat_we    = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_valid_nxt = 1'b1;
                        w_true_nxt  = f_eval(bus.cond, r_status);
                    end
`endif
                end
            end
            S_WAIT: begin
                w_valid_nxt = 1'b1;
                w_true_nxt  = f_eval(r_cond_lat, r_status);
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_status   <= 4'b0000;
            r_shadow   <= 4'b0000;
            r_cond_lat <= 4'b0000;
            r_valid    <= 1'b0;
            r_true     <= 1'b0;
        end else begin
            r_status <= w_status_nxt;
            // Restore wins over save: shadow keeps its value
            if (bus.save && !bus.restore) begin
                r_shadow <= r_status;
            end
            if (w_lat_we) begin
                r_cond_lat <= bus.cond;
            end
            r_valid <= w_valid_nxt;
            r_true  <= w_true_nxt;
        end
    end

`ifdef FLAG_FWD_EN
    assign bus.cond_ready = 1'b1;
`else
    assign bus.cond_ready = (r_state == S_IDLE);
`endif
    assign bus.cond_valid = r_valid;
    assign bus.cond_true  = r_true;
    assign bus.flags_out  = r_status;

endmodule

`default_nettype wire
